// File: rtl/wb_spm_mul_n.sv
// Wishbone-slave serial shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Signed mode multiplies magnitudes and negates at the end; completion raises DONE and an optional irq.
module wb_spm_mul_n #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  state_t          state_r, state_nxt_s;
  logic            ack_r, irq_r;
  logic [31:0]     dat_r;
  logic [WIDTH-1:0] a_r, b_r, mcand_r;
  logic [PW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic [63:0]     p_r;
  logic            signed_r, irq_en_r, done_r, op_sign_r, op_signed_r;

  logic            sel_s, acc_en_s, wr_s, rd_s, busy_s, start_s;
  logic            ctrl_wr_s, status_wr_s;
  logic            signed_nxt_s, irq_en_nxt_s, done_nxt_s;
  logic [2:0]      off_s;
  logic [31:0]     a_mrg_s, b_mrg_s, rdata_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]  sum_s;
  logic [PW-1:0]   step_s, res_s;
  logic [63:0]     ext_s;
  logic            unused_s;

  assign sel_s    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc_en_s = sel_s & ~ack_r;
  assign wr_s     = acc_en_s & wbs_we_i;
  assign rd_s     = acc_en_s & ~wbs_we_i;
  assign off_s    = wbs_adr_i[4:2];
  assign busy_s   = (state_r != IDLE);

  assign ctrl_wr_s   = wr_s & (off_s == 3'd2) & wbs_sel_i[0];
  assign status_wr_s = wr_s & (off_s == 3'd3) & wbs_sel_i[0];
  assign start_s     = ctrl_wr_s & wbs_dat_i[0] & ~busy_s;

  assign a_mrg_s = byte_merge(32'(a_r), wbs_dat_i, wbs_sel_i);
  assign b_mrg_s = byte_merge(32'(b_r), wbs_dat_i, wbs_sel_i);

  assign signed_nxt_s = ctrl_wr_s ? wbs_dat_i[1] : signed_r;
  assign irq_en_nxt_s = ctrl_wr_s ? wbs_dat_i[2] : irq_en_r;

  // The most-negative operand negates to itself, which is still the correct unsigned magnitude.
  assign mag_a_s = (signed_nxt_s & a_r[WIDTH-1]) ? (~a_r + WIDTH'(1)) : a_r;
  assign mag_b_s = (signed_nxt_s & b_r[WIDTH-1]) ? (~b_r + WIDTH'(1)) : b_r;

  assign sum_s  = {1'b0, acc_r[PW-1:WIDTH]} + {1'b0, mcand_r};
  assign step_s = acc_r[0] ? {sum_s, acc_r[WIDTH-1:1]} : {1'b0, acc_r[PW-1:1]};
  assign res_s  = op_sign_r ? (~acc_r + PW'(1)) : acc_r;
  assign ext_s  = op_signed_r ? 64'($signed(res_s)) : 64'(res_s);

  assign unused_s = &{1'b0, wbs_adr_i[7:5], wbs_adr_i[1:0], a_mrg_s, b_mrg_s};

  // DONE sets on the FIX edge and that set takes priority over a W1C or a new START.
  always_comb begin
    done_nxt_s = done_r;
    if (state_r == FIX) begin
      done_nxt_s = 1'b1;
    end else if (start_s) begin
      done_nxt_s = 1'b0;
    end else if (status_wr_s & wbs_dat_i[1]) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
  end

  // Read-data mux over the register map.
  always_comb begin
    rdata_s = 32'h0;
    case (off_s)
      3'd0:    rdata_s = 32'(a_r);
      3'd1:    rdata_s = 32'(b_r);
      3'd2:    rdata_s = {29'h0, irq_en_r, signed_r, 1'b0};
      3'd3:    rdata_s = {30'h0, done_r, busy_s};
      3'd4:    rdata_s = p_r[31:0];
      3'd5:    rdata_s = p_r[63:32];
      default: rdata_s = 32'h0;
    endcase
  end

  // Next-state logic for IDLE -> RUN -> FIX -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(1)) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus interface, programmer-visible registers and the shift-add datapath.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_r       <= 1'b0;
      dat_r       <= 32'h0;
      irq_r       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      mcand_r     <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      p_r         <= 64'h0;
      signed_r    <= 1'b0;
      irq_en_r    <= 1'b0;
      done_r      <= 1'b0;
      op_sign_r   <= 1'b0;
      op_signed_r <= 1'b0;
    end else begin
      ack_r    <= sel_s & ~ack_r;
      dat_r    <= rd_s ? rdata_s : 32'h0;
      signed_r <= signed_nxt_s;
      irq_en_r <= irq_en_nxt_s;
      done_r   <= done_nxt_s;
      irq_r    <= done_nxt_s & irq_en_nxt_s;
      if (wr_s && (off_s == 3'd0)) a_r <= a_mrg_s[WIDTH-1:0];
      if (wr_s && (off_s == 3'd1)) b_r <= b_mrg_s[WIDTH-1:0];
      case (state_r)
        IDLE: begin
          if (start_s) begin
            mcand_r     <= mag_a_s;
            acc_r       <= {{WIDTH{1'b0}}, mag_b_s};
            cnt_r       <= CW'(WIDTH);
            op_sign_r   <= signed_nxt_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            op_signed_r <= signed_nxt_s;
            p_r         <= 64'h0;
          end
        end
        RUN: begin
          acc_r <= step_s;
          cnt_r <= cnt_r - CW'(1);
        end
        FIX:     p_r <= ext_s;
        default: ;
      endcase
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign irq_o     = irq_r;

endmodule

// File: tb/tb_wb_spm_mul_n.sv
// Bench for wb_spm_mul_n: a 32-bit and an 8-bit instance share one Wishbone bus at different bases.
// Read expectations go through a scoreboard queue and are popped when the ack returns data.
module tb_wb_spm_mul_n;

  localparam logic [31:0] B32 = 32'h3000_0000;
  localparam logic [31:0] B8  = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack32, ack8, irq32, irq8;
  logic [31:0] dat32, dat8;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];

  typedef struct {
    bit          w8;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vt[10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_spm_mul_n #(.WIDTH(32), .BASE_ADDR(B32)) u32 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack32),
    .wbs_dat_o(dat32), .irq_o(irq32));

  wb_spm_mul_n #(.WIDTH(8), .BASE_ADDR(B8)) u8 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack8),
    .wbs_dat_o(dat8), .irq_o(irq8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output bit got);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    got = 1'b0; rd = 32'h0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(posedge clk); #1;
      if (ack32 | ack8) begin
        got = 1'b1;
        rd = ack32 ? dat32 : dat8;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s = 4'hF);
    logic [31:0] rd;
    bit got;
    bus(a, 1'b1, d, s, rd, got);
    check({name, "_ack"}, {31'h0, got}, 32'h1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] rd, e2;
    string n2;
    bit got;
    exp_q.push_back(e);
    nm_q.push_back(name);
    bus(a, 1'b0, 32'h0, 4'hF, rd, got);
    e2 = exp_q.pop_front();
    n2 = nm_q.pop_front();
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: no ack, expected data 0x%08h", n2, e2);
    end else begin
      check(n2, rd, e2);
    end
  endtask

  task automatic wait_done(input string name, input logic [31:0] base);
    logic [31:0] rd;
    bit got, done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      bus(base + 32'h0C, 1'b0, 32'h0, 4'hF, rd, got);
      done = got & rd[1];
    end
    check({name, "_done"}, {31'h0, done}, 32'h1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, rd;
    bit got;
    int t0, n;

    vt[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
    vt[1] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF};
    vt[2] = '{1'b1, 1'b0, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_FE01, 32'h0000_0000};
    vt[3] = '{1'b1, 1'b1, 32'h0000_0080, 32'h0000_0080, 32'h0000_4000, 32'h0000_0000};
    vt[4] = '{1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0000_0080, 32'h0000_4000, 32'h0000_0000};
    vt[6] = '{1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vt[7] = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000};
    vt[8] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001};
    vt[9] = '{1'b1, 1'b1, 32'h0000_007F, 32'h0000_0081, 32'hFFFF_C0FF, 32'hFFFF_FFFF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, ack32}, 32'h0);
    check("rst_dat", dat32, 32'h0);
    check("rst_irq", {30'h0, irq32, irq8}, 32'h0);
    rst_n = 1'b1;

    rd_chk("rst_a", B32 + 32'h00, 32'h0);
    rd_chk("rst_ctrl", B32 + 32'h08, 32'h0);
    rd_chk("rst_status", B32 + 32'h0C, 32'h0);
    rd_chk("rst_plo", B32 + 32'h10, 32'h0);
    rd_chk("rst_phi", B32 + 32'h14, 32'h0);

    wr("a_lanes", B32 + 32'h00, 32'hAABB_CCDD, 4'b0101);
    rd_chk("a_lanes", B32 + 32'h00, 32'h00BB_00DD);
    wr("a8_wide", B8 + 32'h00, 32'hFFFF_FFFF);
    rd_chk("a8_upper0", B8 + 32'h00, 32'h0000_00FF);

    for (int i = 0; i < 10; i++) begin
      base = vt[i].w8 ? B8 : B32;
      wr($sformatf("v%0d_a", i), base + 32'h00, vt[i].a);
      wr($sformatf("v%0d_b", i), base + 32'h04, vt[i].b);
      wr($sformatf("v%0d_go", i), base + 32'h08, {30'h0, vt[i].sgn, 1'b1});
      wait_done($sformatf("v%0d", i), base);
      rd_chk($sformatf("v%0d_plo", i), base + 32'h10, vt[i].lo);
      rd_chk($sformatf("v%0d_phi", i), base + 32'h14, vt[i].hi);
      rd_chk($sformatf("v%0d_status", i), base + 32'h0C, 32'h2);
    end

    // START while busy is ignored; BUSY lasts exactly WIDTH+1 cycles.
    wr("bz_a", B32 + 32'h00, 32'd5);
    wr("bz_b", B32 + 32'h04, 32'd6);
    wr("bz_go", B32 + 32'h08, 32'h5);
    t0 = cyc_cnt;
    rd_chk("bz_busy", B32 + 32'h0C, 32'h1);
    wr("bz_a2", B32 + 32'h00, 32'd2);
    wr("bz_b2", B32 + 32'h04, 32'd2);
    wr("bz_go2", B32 + 32'h08, 32'h5);
    rd_chk("bz_a2_rd", B32 + 32'h00, 32'd2);
    n = 0;
    while (!irq32 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bz_latency", cyc_cnt - t0, 32'd33);
    rd_chk("bz_plo", B32 + 32'h10, 32'd30);
    rd_chk("bz_phi", B32 + 32'h14, 32'd0);
    rd_chk("bz_status", B32 + 32'h0C, 32'h2);
    check("irq_set", {31'h0, irq32}, 32'h1);

    wr("w1c", B32 + 32'h0C, 32'h2);
    check("irq_clr", {31'h0, irq32}, 32'h0);
    rd_chk("w1c_status", B32 + 32'h0C, 32'h0);

    wr("noirq_go", B32 + 32'h08, 32'h1);
    wait_done("noirq", B32);
    check("noirq_irq", {31'h0, irq32}, 32'h0);
    rd_chk("noirq_plo", B32 + 32'h10, 32'd4);

    // Reset in the middle of a RUN, with the 8-bit instance holding an active irq.
    wr("r8_a", B8 + 32'h00, 32'd3);
    wr("r8_go", B8 + 32'h08, 32'h5);
    wait_done("r8", B8);
    check("r8_irq", {31'h0, irq8}, 32'h1);
    wr("rm_a", B32 + 32'h00, 32'd7);
    wr("rm_b", B32 + 32'h04, 32'd9);
    wr("rm_go", B32 + 32'h08, 32'h5);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rm_irq8", {31'h0, irq8}, 32'h0);
    check("rm_ack", {31'h0, ack32}, 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    rd_chk("rm_status", B32 + 32'h0C, 32'h0);
    rd_chk("rm_plo", B32 + 32'h10, 32'h0);
    rd_chk("rm_phi", B32 + 32'h14, 32'h0);
    rd_chk("rm_ctrl8", B8 + 32'h08, 32'h0);
    rd_chk("unmapped", B32 + 32'h18, 32'h0);

    bus(32'h4000_0000, 1'b0, 32'h0, 4'hF, rd, got);
    check("other_base_noack", {31'h0, got}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
